// File: rtl/sram_copy_engine.sv
// Copy/fill initiator for a single sram_bank: up to two reads in flight, one
// word per cycle sustained, range/overlap checks at accept and a response timeout.
module sram_copy_engine #(
    parameter int BANK_DEPTH     = 256,
    parameter int DATA_WIDTH     = 64,
    parameter int ADDR_BITS      = $clog2(BANK_DEPTH),
    parameter int LEN_BITS       = ADDR_BITS + 1,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_fill,
    input  logic [ADDR_BITS-1:0]  cmd_src,
    input  logic [ADDR_BITS-1:0]  cmd_dst,
    input  logic [LEN_BITS-1:0]   cmd_len,
    input  logic [DATA_WIDTH-1:0] cmd_pattern,
    output logic                  bank_enable,
    output logic                  read_valid,
    output logic [ADDR_BITS-1:0]  read_address,
    input  logic                  read_ready,
    input  logic [DATA_WIDTH-1:0] read_data,
    output logic                  write_valid,
    output logic [ADDR_BITS-1:0]  write_address,
    output logic [DATA_WIDTH-1:0] write_data,
    input  logic                  write_ready,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [1:0]            error_code,
    output logic [LEN_BITS-1:0]   words_done
);

    localparam int                 XW       = LEN_BITS + 1;
    localparam logic [XW-1:0]      DEPTH_X  = XW'(BANK_DEPTH);
    localparam int                 TO_BITS  = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_BITS-1:0] TO_LAST  = TO_BITS'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE,
        S_ERR
    } state_t;

    state_t                state_q, state_d;
    logic                  fill_q, fill_d;
    logic [LEN_BITS-1:0]   len_q, len_d;
    logic [ADDR_BITS-1:0]  src_ptr_q, src_ptr_d;
    logic [ADDR_BITS-1:0]  dst_ptr_q, dst_ptr_d;
    logic [DATA_WIDTH-1:0] pattern_q, pattern_d;
    logic [LEN_BITS-1:0]   rd_left_q, rd_left_d;
    logic [1:0]            rd_out_q, rd_out_d;
    logic [LEN_BITS-1:0]   wr_cnt_q, wr_cnt_d;
    logic [TO_BITS-1:0]    to_cnt_q, to_cnt_d;

    logic                  cmd_ready_q, cmd_ready_d;
    logic                  bank_enable_q, bank_enable_d;
    logic                  read_valid_q, read_valid_d;
    logic [ADDR_BITS-1:0]  read_address_q, read_address_d;
    logic                  write_valid_q, write_valid_d;
    logic [ADDR_BITS-1:0]  write_address_q, write_address_d;
    logic [DATA_WIDTH-1:0] write_data_q, write_data_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  error_q, error_d;
    logic [1:0]            error_code_q, error_code_d;
    logic [LEN_BITS-1:0]   words_done_q, words_done_d;

    logic [XW-1:0] src_x, dst_x, len_x;
    logic          range_bad, overlap_bad;
    logic          active, rd_hit, wr_hit, pending, issue_rd;
    logic [1:0]    rd_out_after;

    always_comb begin
        src_x       = XW'(cmd_src);
        dst_x       = XW'(cmd_dst);
        len_x       = XW'(cmd_len);
        range_bad   = (dst_x + len_x > DEPTH_X) || (!cmd_fill && (src_x + len_x > DEPTH_X));
        overlap_bad = !cmd_fill && (src_x < dst_x) && (dst_x < src_x + len_x);
    end

    always_comb begin
        state_d         = state_q;
        fill_d          = fill_q;
        len_d           = len_q;
        src_ptr_d       = src_ptr_q;
        dst_ptr_d       = dst_ptr_q;
        pattern_d       = pattern_q;
        rd_left_d       = rd_left_q;
        rd_out_d        = rd_out_q;
        wr_cnt_d        = wr_cnt_q;
        to_cnt_d        = to_cnt_q;
        read_valid_d    = 1'b0;
        read_address_d  = read_address_q;
        write_valid_d   = 1'b0;
        write_address_d = write_address_q;
        write_data_d    = write_data_q;
        done_d          = 1'b0;
        error_d         = error_q;
        error_code_d    = error_code_q;
        issue_rd        = 1'b0;

        // Responses count only while a job owns the bank; late ones after ERR are dropped.
        active       = (state_q == S_RUN) || (state_q == S_DRAIN);
        rd_hit       = active && !fill_q && read_ready && (rd_out_q != 2'd0);
        wr_hit       = active && write_ready && (wr_cnt_q != words_done_q);
        pending      = (rd_out_q != 2'd0) || (wr_cnt_q != words_done_q);
        rd_out_after = rd_out_q - {1'b0, rd_hit};
        words_done_d = wr_hit ? words_done_q + 1'b1 : words_done_q;

        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    fill_d       = cmd_fill;
                    len_d        = cmd_len;
                    pattern_d    = cmd_pattern;
                    src_ptr_d    = cmd_src;
                    dst_ptr_d    = cmd_dst;
                    rd_left_d    = '0;
                    rd_out_d     = '0;
                    wr_cnt_d     = '0;
                    to_cnt_d     = '0;
                    words_done_d = '0;
                    error_d      = 1'b0;
                    error_code_d = 2'd0;
                    if (range_bad) begin
                        state_d      = S_ERR;
                        error_d      = 1'b1;
                        error_code_d = 2'd1;
                    end else if (overlap_bad) begin
                        state_d      = S_ERR;
                        error_d      = 1'b1;
                        error_code_d = 2'd2;
                    end else if (cmd_len == '0) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_RUN;
                        // First beat leaves on the accept edge so it appears in the next cycle.
                        if (cmd_fill) begin
                            write_valid_d   = 1'b1;
                            write_address_d = cmd_dst;
                            write_data_d    = cmd_pattern;
                            dst_ptr_d       = cmd_dst + 1'b1;
                            wr_cnt_d        = LEN_BITS'(1);
                        end else begin
                            read_valid_d   = 1'b1;
                            read_address_d = cmd_src;
                            src_ptr_d      = cmd_src + 1'b1;
                            rd_left_d      = cmd_len - 1'b1;
                            rd_out_d       = 2'd1;
                        end
                    end
                end
            end

            S_RUN, S_DRAIN: begin
                if (rd_hit || wr_hit) begin
                    to_cnt_d = '0;
                end else if (pending) begin
                    to_cnt_d = to_cnt_q + 1'b1;
                end
                rd_out_d = rd_out_after;

                if (!(rd_hit || wr_hit) && pending && (to_cnt_q == TO_LAST)) begin
                    state_d      = S_ERR;
                    error_d      = 1'b1;
                    error_code_d = 2'd3;
                end else if (state_q == S_RUN) begin
                    if (wr_cnt_q == len_q) begin
                        state_d = S_DRAIN;
                    end else if (fill_q) begin
                        write_valid_d   = 1'b1;
                        write_address_d = dst_ptr_q;
                        write_data_d    = pattern_q;
                        dst_ptr_d       = dst_ptr_q + 1'b1;
                        wr_cnt_d        = wr_cnt_q + 1'b1;
                    end else begin
                        issue_rd = (rd_left_q != '0) && (rd_out_after != 2'd2);
                        if (issue_rd) begin
                            read_valid_d   = 1'b1;
                            read_address_d = src_ptr_q;
                            src_ptr_d      = src_ptr_q + 1'b1;
                            rd_left_d      = rd_left_q - 1'b1;
                        end
                        rd_out_d = rd_out_after + {1'b0, issue_rd};
                        if (rd_hit) begin
                            write_valid_d   = 1'b1;
                            write_address_d = dst_ptr_q;
                            write_data_d    = read_data;
                            dst_ptr_d       = dst_ptr_q + 1'b1;
                            wr_cnt_d        = wr_cnt_q + 1'b1;
                        end
                    end
                end else if (words_done_d == len_q) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end
            end

            S_DONE:  state_d = S_IDLE;
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        busy_d        = (state_d == S_RUN) || (state_d == S_DRAIN);
        bank_enable_d = busy_d;
        cmd_ready_d   = (state_d == S_IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q         <= S_IDLE;
            fill_q          <= 1'b0;
            len_q           <= '0;
            src_ptr_q       <= '0;
            dst_ptr_q       <= '0;
            pattern_q       <= '0;
            rd_left_q       <= '0;
            rd_out_q        <= '0;
            wr_cnt_q        <= '0;
            to_cnt_q        <= '0;
            cmd_ready_q     <= 1'b1;
            bank_enable_q   <= 1'b0;
            read_valid_q    <= 1'b0;
            read_address_q  <= '0;
            write_valid_q   <= 1'b0;
            write_address_q <= '0;
            write_data_q    <= '0;
            busy_q          <= 1'b0;
            done_q          <= 1'b0;
            error_q         <= 1'b0;
            error_code_q    <= 2'd0;
            words_done_q    <= '0;
        end else begin
            state_q         <= state_d;
            fill_q          <= fill_d;
            len_q           <= len_d;
            src_ptr_q       <= src_ptr_d;
            dst_ptr_q       <= dst_ptr_d;
            pattern_q       <= pattern_d;
            rd_left_q       <= rd_left_d;
            rd_out_q        <= rd_out_d;
            wr_cnt_q        <= wr_cnt_d;
            to_cnt_q        <= to_cnt_d;
            cmd_ready_q     <= cmd_ready_d;
            bank_enable_q   <= bank_enable_d;
            read_valid_q    <= read_valid_d;
            read_address_q  <= read_address_d;
            write_valid_q   <= write_valid_d;
            write_address_q <= write_address_d;
            write_data_q    <= write_data_d;
            busy_q          <= busy_d;
            done_q          <= done_d;
            error_q         <= error_d;
            error_code_q    <= error_code_d;
            words_done_q    <= words_done_d;
        end
    end

    assign cmd_ready     = cmd_ready_q;
    assign bank_enable   = bank_enable_q;
    assign read_valid    = read_valid_q;
    assign read_address  = read_address_q;
    assign write_valid   = write_valid_q;
    assign write_address = write_address_q;
    assign write_data    = write_data_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign error         = error_q;
    assign error_code    = error_code_q;
    assign words_done    = words_done_q;

endmodule

// File: doc/sram_copy_engine.md
Name: sram_copy_engine

Overview:
Initiator that drives the read and write ports of one sram_bank to copy a word range, or to fill a range with a constant.
- Sits between the control/command path and a single bank.
- Owns the bank power-enable while a job runs.
- Pipelined for 1 word/cycle sustained throughput.
- Reports busy, done and error status back to the command issuer.

Parameters:
- BANK_DEPTH, 256, rows in the target bank.
- DATA_WIDTH, 64, bits per row.
- ADDR_BITS, $clog2(BANK_DEPTH), bank address width.
- LEN_BITS, ADDR_BITS+1, job length width (allows length = BANK_DEPTH).
- TIMEOUT_CYCLES, 16, cycles without any bank response before the job errors.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- cmd_valid  in  1  job request
- cmd_ready  out  1  engine idle, can accept a job
- cmd_fill  in  1  1 = fill mode, 0 = copy mode
- cmd_src  in  ADDR_BITS  copy source start row
- cmd_dst  in  ADDR_BITS  destination start row
- cmd_len  in  LEN_BITS  number of words
- cmd_pattern  in  DATA_WIDTH  fill value
- bank_enable  out  1  drives sram_bank enable
- read_valid  out  1  bank read request
- read_address  out  ADDR_BITS  bank read row
- read_ready  in  1  bank read response
- read_data  in  DATA_WIDTH  bank read data
- write_valid  out  1  bank write request
- write_address  out  ADDR_BITS  bank write row
- write_data  out  DATA_WIDTH  bank write data
- write_ready  in  1  bank write acknowledge
- busy  out  1  job in progress
- done  out  1  one-cycle pulse on successful completion
- error  out  1  sticky error flag, cleared on next accepted job
- error_code  out  2  0 none, 1 range, 2 overlap, 3 timeout
- words_done  out  LEN_BITS  write acknowledges counted for the current job

Behaviour:
- Reset (async): state IDLE.
  - All outputs 0, except cmd_ready = 1.
  - Counters cleared.
  - Reset mid-job abandons the job; bank contents are left as partially written.
- Outputs: all registered.
  - cmd_ready = (state==IDLE).
  - busy = (state in RUN, DRAIN).
  - bank_enable = busy.
- States: IDLE, RUN, DRAIN, DONE, ERR.
- IDLE: a job is accepted when cmd_valid && cmd_ready. On accept:
  - Capture all cmd fields.
  - Clear error, error_code and words_done.
  - Range check, error_code 1: cmd_dst+cmd_len > BANK_DEPTH, or (copy mode and cmd_src+cmd_len > BANK_DEPTH). Compute at LEN_BITS+1 width; no wrap-around is permitted.
  - Overlap check, error_code 2: copy mode and cmd_src < cmd_dst < cmd_src+cmd_len.
  - Either check failing goes to ERR. No bank traffic is issued.
  - cmd_len == 0 with checks passing goes directly to DONE.
  - Otherwise go to RUN.
- RUN, copy mode:
  - Issue read_valid with ascending read_address, starting at cmd_src, one per cycle.
  - Stall (read_valid = 0) while reads outstanding == 2. Outstanding = read_valid issued minus read_ready seen.
  - Each read_ready sampled: next cycle assert write_valid with write_address = dst pointer (ascending from cmd_dst) and write_data = sampled read_data.
  - Read issued at cycle t: write_valid at t+2, write_ready at t+3.
- RUN, fill mode:
  - No reads.
  - write_valid on every cycle of RUN with write_data = cmd_pattern, ascending addresses, cmd_len consecutive cycles.
- RUN to DRAIN after the final write is issued.
- DRAIN: wait until words_done == cmd_len, then go to DONE.
- words_done increments on each sampled write_ready.
- DONE: done = 1 for exactly one cycle, then IDLE.
- Timeout:
  - In RUN or DRAIN, a counter increments each cycle where outstanding reads or writes exist and neither read_ready nor write_ready is sampled.
  - The counter resets on any ready.
  - Reaching TIMEOUT_CYCLES: stop issuing, go to ERR, error_code 3.
- ERR:
  - error = 1 (sticky).
  - One cycle in ERR, then IDLE.
  - Late read_ready/write_ready after ERR are ignored.
- cmd_valid while not IDLE: ignored; the command is not queued.
- Simultaneous read_ready and write_ready in one cycle: both are processed.

Test Plan:
- Reset with cmd_valid=1 held -> all outputs 0, cmd_ready=1, no job accepted until reset drops.
- Copy with bank preloaded rows 0..3 = 0xA0..0xA3, src=0, dst=8, len=4:
  - read_valid high cycles 1-4; write_valid high cycles 3-6.
  - Rows 8..11 = 0xA0..0xA3.
  - done pulse at cycle 8; words_done=4.
- Fill with dst=250, len=6, pattern=0xDEAD -> rows 250..255 = 0xDEAD; no read_valid ever; done pulse; error=0.
- Range error: dst=252, len=5 -> error=1, error_code=1, no write_valid; separately, len=0 -> done pulse, no bank traffic.
- Overlap: src=10, dst=12, len=4 -> error_code=2; src=12, dst=10, len=4 -> accepted, rows 10..13 = old rows 12..15.
- Timeout: bank enable forced low mid copy (len=8) -> no ready for 16 cycles -> error_code=3, busy falls, next job accepted clears error.
